uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single byte-level UART transmitter among four status/reply requesters by round-robin arbitration. It packs each granted request into an 8-byte reply frame and sequences that frame into the transmitter one byte at a time. The frame uses the same header/tail convention as the inbound command path: 0x55, 0xA5, payload, 0xF0. A watchdog aborts a frame if the transmitter stops acknowledging bytes.

## Interface
- Clock and reset (already decided): one clock, `Clk`; reset `Reset` is asynchronous and active-high.
- `TIMEOUT`, default 100000: max cycles to wait for `Tx_Done` after each `Send_En`.
- `TO_W`, default 17: width of the watchdog counter; must hold `TIMEOUT`.
- `Clk` in 1: system clock.
- `Reset` in 1: async active-high reset.
- `req` in 4: per-requester request level.
- `req_data` in 96: payload; requester k uses `[24k+23:24k]`.
- `Tx_Done` in 1: one-cycle pulse from the UART TX when a byte has finished.
- `Send_En` out 1: one-cycle pulse that starts a byte on the UART TX.
- `Tx_Data` out 8: byte to send; valid while `Send_En` is high and held until the next `Send_En`.
- `ack` out 4: one-hot, one-cycle pulse; the granted requester's payload has been captured.
- `busy` out 1: high from grant until frame end or abort.
- `cur_id` out 2: index of the granted requester; valid while `busy`.
- `frame_done` out 1: one-cycle pulse after the last byte's `Tx_Done`.
- `timeout_err` out 1: one-cycle pulse when a frame is aborted.

## Operation
- Frame byte order:
  - byte0 = 0x55
  - byte1 = 0xA5
  - byte2 = {6'b0, id}
  - bytes 3–5 = payload[23:16], [15:8], [7:0]
  - byte6 = XOR of bytes 2–5
  - byte7 = 0xF0
- States: IDLE, WAIT.
- IDLE:
  - `req` is sampled only in IDLE.
  - If any bit is set, grant the first set bit at or after `rr_ptr`, scanning upward with wrap 3→0.
  - On grant: capture the payload and the checksum, set `byte_idx`=0, and go to WAIT.
- WAIT:
  - When `Tx_Done` arrives and `byte_idx`<7: increment `byte_idx` and re-issue `Send_En` with the next byte.
  - When `Tx_Done` arrives and `byte_idx`==7: go to IDLE and pulse `frame_done`.
- Round-robin pointer: `rr_ptr` = granted id + 1 (mod 4). It updates at grant time, regardless of whether the frame later completes or aborts.
- Watchdog:
  - The counter clears on each `Send_En` and increments every WAIT cycle without `Tx_Done`.
  - When it reaches `TIMEOUT`: pulse `timeout_err`, deassert `busy`, go to IDLE. No `frame_done` is issued.
- Ignored `Tx_Done`: a `Tx_Done` in IDLE, or in the same cycle as `Send_En`, is ignored.
- Requester obligations:
  - Hold `req` and `req_data` stable until `ack`.
  - A `req` still high when the arbiter returns to IDLE is treated as a new request.
- Reset values: all outputs are 0, `rr_ptr`=0, state IDLE, counters 0.
- Reset asserted mid-frame: outputs clear immediately (asynchronously). No partial frame resumes after release.

## Timing
- Grant: IDLE sees `req` in cycle t. In cycle t+1 the outputs are `ack`, `busy`=1, `cur_id`, `Send_En`=1, `Tx_Data`=0x55.
- Byte advance: `Tx_Done` in cycle u gives `Send_En` with the next byte in cycle u+1.
- Frame end: the byte7 `Tx_Done` in cycle u gives `frame_done`=1 and `busy`=0 in cycle u+1.
  - A pending request is sampled in u+1.
  - The next frame's `Send_En` is at u+2 at the earliest.
- Frame latency: 1 + 8 × (TX byte time + 1) cycles.
- Timeout: if no `Tx_Done` arrives in the `TIMEOUT` cycles after `Send_En`, `timeout_err` and `busy`=0 appear on the next cycle.
- All outputs are registered.

## Test plan
- Single frame:
  - Stimulus: `req`=0100, payload 0x123456, TX model with `Tx_Done` 10 cycles after each `Send_En`.
  - Required: bytes 55 A5 02 12 34 56 72 F0 in order, `ack`=0100 once, one `frame_done`, `cur_id`=2 throughout.
- Round-robin:
  - Stimulus: `req`=1111 held continuously after reset.
  - Required: grant order 0, 1, 2, 3, 0; each frame completes before the next `ack`.
- Priority skip:
  - Stimulus: after a grant to 1, assert `req`=0001 and 1000 together.
  - Required: 3 is granted before 0.
- Timeout:
  - Stimulus: `TIMEOUT`=50; TX model withholds `Tx_Done` after byte3.
  - Required: `timeout_err` pulses 51 cycles after that `Send_En`, `busy`=0, no `frame_done`, the next request is served normally.
- Reset mid-frame:
  - Stimulus: assert `Reset` during byte4.
  - Required: `Send_En`, `busy` and `ack` go to 0 immediately; after release, `req`=0010 yields a fresh frame starting 0x55 with id 1.
- Stray `Tx_Done`:
  - Stimulus: pulse `Tx_Done` while IDLE, and in the same cycle as `Send_En`.
  - Required: no byte advance and no `frame_done`.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one byte-level UART TX
// among four requesters, sent as 8-byte framed replies.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT = 100000,
  parameter int unsigned TO_W    = 17
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [95:0] req_data,
  input  logic        Tx_Done,
  output logic        Send_En,
  output logic [7:0]  Tx_Data,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [1:0]  cur_id,
  output logic        frame_done,
  output logic        timeout_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_e;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hA5;
  localparam logic [7:0] TAIL = 8'hF0;

  state_e          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [2:0]      idx_q, idx_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [23:0]     pay_q, pay_d;
  logic [7:0]      chk_q, chk_d;
  logic            send_q, send_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      ack_q, ack_d;
  logic            busy_q, busy_d;
  logic [1:0]      id_q, id_d;
  logic            done_q, done_d;
  logic            terr_q, terr_d;

  logic            gnt_vld;
  logic [1:0]      gnt_id;
  logic [1:0]      cand;
  logic [23:0]     gnt_pay;
  logic [7:0]      gnt_chk;
  logic            tx_ok;
  logic            wd_exp;
  logic [2:0]      idx_nx;

  // Byte i of the reply frame for requester id with payload p.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]  i,
    input logic [1:0]  id,
    input logic [23:0] p,
    input logic [7:0]  c
  );
    logic [7:0] b;
    b = 8'h00;
    case (i)
      3'd0: b = HDR0;
      3'd1: b = HDR1;
      3'd2: b = {6'b0, id};
      3'd3: b = p[23:16];
      3'd4: b = p[15:8];
      3'd5: b = p[7:0];
      3'd6: b = c;
      3'd7: b = TAIL;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Round-robin scan: first set req at or after rr_ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = rr_ptr_q;
    cand    = rr_ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = rr_ptr_q + 2'(i);
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // Payload slice and checksum of the candidate grant.
  always_comb begin
    gnt_pay = req_data[23:0];
    case (gnt_id)
      2'd0: gnt_pay = req_data[23:0];
      2'd1: gnt_pay = req_data[47:24];
      2'd2: gnt_pay = req_data[71:48];
      2'd3: gnt_pay = req_data[95:72];
      default: gnt_pay = req_data[23:0];
    endcase
    gnt_chk = {6'b0, gnt_id} ^ gnt_pay[23:16]
            ^ gnt_pay[15:8] ^ gnt_pay[7:0];
  end

  // A Tx_Done in the Send_En cycle belongs to no byte of ours.
  assign tx_ok  = Tx_Done & ~send_q;
  assign wd_exp = (wd_q == TO_W'(TIMEOUT));
  assign idx_nx = idx_q + 3'd1;

  // Next-state and registered-output logic of the frame sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    pay_d    = pay_q;
    chk_d    = chk_q;
    send_d   = 1'b0;
    data_d   = data_q;
    ack_d    = 4'b0;
    busy_d   = busy_q;
    id_d     = id_q;
    done_d   = 1'b0;
    terr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          ack_d    = 4'b0001 << gnt_id;
          busy_d   = 1'b1;
          id_d     = gnt_id;
          pay_d    = gnt_pay;
          chk_d    = gnt_chk;
          idx_d    = 3'd0;
          wd_d     = '0;
          send_d   = 1'b1;
          data_d   = HDR0;
          rr_ptr_d = gnt_id + 2'd1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (tx_ok) begin
          if (idx_q == 3'd7) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d  = idx_nx;
            send_d = 1'b1;
            data_d = frame_byte(idx_nx, id_q, pay_q, chk_q);
            wd_d   = '0;
          end
        end else if (wd_exp) begin
          terr_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers, cleared asynchronously by Reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 2'd0;
      idx_q    <= 3'd0;
      wd_q     <= '0;
      pay_q    <= 24'd0;
      chk_q    <= 8'd0;
      send_q   <= 1'b0;
      data_q   <= 8'd0;
      ack_q    <= 4'd0;
      busy_q   <= 1'b0;
      id_q     <= 2'd0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      pay_q    <= pay_d;
      chk_q    <= chk_d;
      send_q   <= send_d;
      data_q   <= data_d;
      ack_q    <= ack_d;
      busy_q   <= busy_d;
      id_q     <= id_d;
      done_q   <= done_d;
      terr_q   <= terr_d;
    end
  end

  assign Send_En     = send_q;
  assign Tx_Data     = data_q;
  assign ack         = ack_q;
  assign busy        = busy_q;
  assign cur_id      = id_q;
  assign frame_done  = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of framing, round-robin,
// watchdog abort, reset mid-frame and stray Tx_Done handling.
module tb_uart_tx_arbiter;

  logic        Clk;
  logic        Reset;
  logic [3:0]  req;
  logic [95:0] req_data;
  logic        Tx_Done;
  logic        Send_En;
  logic [7:0]  Tx_Data;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  cur_id;
  logic        frame_done;
  logic        timeout_err;

  uart_tx_arbiter #(
    .TIMEOUT(50),
    .TO_W(17)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .req(req),
    .req_data(req_data),
    .Tx_Done(Tx_Done),
    .Send_En(Send_En),
    .Tx_Data(Tx_Data),
    .ack(ack),
    .busy(busy),
    .cur_id(cur_id),
    .frame_done(frame_done),
    .timeout_err(timeout_err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  int   cyc = 0;
  int   tx_cnt = 0;
  int   tx_delay = 10;
  int   tx_limit = 99;
  int   n_sent = 0;
  bit   stray_idle = 0;
  bit   stray_same = 0;
  bit   id_en = 0;
  logic [1:0] exp_id = 2'd0;
  int   id_bad = 0;

  logic [7:0] byte_q[$];
  int         send_cyc[$];
  logic [3:0] ack_q[$];
  int         ack_cyc[$];
  int         fd_at_ack[$];
  int         fd_cyc[$];
  int         fd_cnt = 0;
  int         to_cnt = 0;
  int         to_cyc = 0;
  logic       to_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_logs();
    byte_q.delete();
    send_cyc.delete();
    ack_q.delete();
    ack_cyc.delete();
    fd_at_ack.delete();
    fd_cyc.delete();
    fd_cnt = 0;
    to_cnt = 0;
    n_sent = 0;
  endtask

  task automatic set_pay(input int k, input logic [23:0] v);
    req_data[24*k +: 24] = v;
  endtask

  task automatic wait_ack(input string tag, input int n, input int budget);
    int k = 0;
    while (ack_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, ack_q.size(), n);
  endtask

  task automatic wait_fd(input string tag, input int n, input int budget);
    int k = 0;
    while (fd_cnt < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, fd_cnt, n);
  endtask

  task automatic wait_to(input string tag, input int budget);
    int k = 0;
    while (to_cnt < 1 && k < budget) begin
      tick();
      k++;
    end
    check(tag, to_cnt, 1);
  endtask

  task automatic check_frame(input string tag, input logic [63:0] exp);
    logic [31:0] got;
    check({tag, "_len"}, byte_q.size(), 8);
    for (int k = 0; k < 8; k++) begin
      got = (k < byte_q.size()) ? {24'd0, byte_q[k]} : 32'hDEAD;
      check($sformatf("%s_b%0d", tag, k), got, {24'd0, exp[63-8*k -: 8]});
    end
  endtask

  // TX model and event monitor, acting 2 time units after each edge.
  initial begin
    Tx_Done = 1'b0;
    forever begin
      @(posedge Clk);
      #2;
      cyc++;
      if (Reset) begin
        tx_cnt  = 0;
        Tx_Done = 1'b0;
      end else begin
        Tx_Done = 1'b0;
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) Tx_Done = 1'b1;
        end
        if (Send_En) begin
          if (n_sent < tx_limit) tx_cnt = tx_delay;
          n_sent++;
          if (stray_same) begin
            Tx_Done    = 1'b1;
            stray_same = 0;
          end
        end
        if (stray_idle) begin
          Tx_Done    = 1'b1;
          stray_idle = 0;
        end
      end
      if (Send_En) begin
        byte_q.push_back(Tx_Data);
        send_cyc.push_back(cyc);
      end
      if (ack != 4'd0) begin
        ack_q.push_back(ack);
        ack_cyc.push_back(cyc);
        fd_at_ack.push_back(fd_cnt);
      end
      if (frame_done) begin
        fd_cnt++;
        fd_cyc.push_back(cyc);
      end
      if (timeout_err) begin
        to_cnt++;
        to_cyc  = cyc;
        to_busy = busy;
      end
      if (id_en && busy && cur_id != exp_id) id_bad++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    int k;
    Reset    = 1'b1;
    req      = 4'b0000;
    req_data = 96'd0;
    tick();
    tick();
    check("rst_send", Send_En, 0);
    check("rst_data", Tx_Data, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_id", cur_id, 0);
    check("rst_fd", frame_done, 0);
    check("rst_to", timeout_err, 0);
    Reset = 1'b0;
    tick();
    clear_logs();

    // single frame, requester 2
    set_pay(2, 24'h123456);
    exp_id = 2'd2;
    id_en  = 1;
    req    = 4'b0100;
    wait_ack("sf_ack_wait", 1, 20);
    req = 4'b0000;
    wait_fd("sf_fd_wait", 1, 200);
    repeat (5) tick();
    id_en = 0;
    check_frame("sf", 64'h55A50212345672F0);
    check("sf_ack_val", ack_q.size() > 0 ? ack_q[0] : 4'hF, 4'b0100);
    check("sf_ack_cnt", ack_q.size(), 1);
    check("sf_fd_cnt", fd_cnt, 1);
    check("sf_id_hold", id_bad, 0);
    if (fd_cyc.size() > 0 && ack_cyc.size() > 0)
      check("sf_latency", fd_cyc[0] - ack_cyc[0], 88);
    if (send_cyc.size() > 1)
      check("sf_gap", send_cyc[1] - send_cyc[0], 11);

    // round-robin with all requests held
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    clear_logs();
    set_pay(0, 24'h000001);
    set_pay(1, 24'h000002);
    set_pay(3, 24'h000004);
    req = 4'b1111;
    wait_ack("rr_ack_wait", 5, 600);
    req = 4'b0000;
    wait_fd("rr_fd_wait", 5, 200);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr_ack%0d", i),
            i < ack_q.size() ? ack_q[i] : 4'hF, 4'b0001 << (i % 4));
      check($sformatf("rr_order%0d", i),
            i < fd_at_ack.size() ? fd_at_ack[i] : -1, i);
    end
    if (ack_cyc.size() > 1 && fd_cyc.size() > 0)
      check("rr_regrant_gap", ack_cyc[1] - fd_cyc[0], 1);

    // priority skip: after grant to 1, requests 0 and 3 together
    clear_logs();
    req = 4'b0010;
    wait_ack("ps_ack1_wait", 1, 20);
    req = 4'b1001;
    wait_ack("ps_ack2_wait", 2, 200);
    req = 4'b0001;
    wait_ack("ps_ack3_wait", 3, 200);
    req = 4'b0000;
    wait_fd("ps_fd_wait", 3, 200);
    check("ps_first", ack_q.size() > 0 ? ack_q[0] : 4'hF, 4'b0010);
    check("ps_second", ack_q.size() > 1 ? ack_q[1] : 4'hF, 4'b1000);
    check("ps_third", ack_q.size() > 2 ? ack_q[2] : 4'hF, 4'b0001);

    // watchdog: Tx_Done withheld for byte3
    clear_logs();
    tx_limit = 3;
    set_pay(2, 24'h777777);
    req = 4'b0100;
    wait_ack("to_ack_wait", 1, 20);
    req = 4'b0000;
    wait_to("to_wait", 300);
    check("to_bytes", byte_q.size(), 4);
    if (send_cyc.size() > 3)
      check("to_delay", to_cyc - send_cyc[3], 51);
    check("to_busy", to_busy, 0);
    repeat (5) tick();
    check("to_no_fd", fd_cnt, 0);
    check("to_busy_now", busy, 0);
    clear_logs();
    tx_limit = 99;
    set_pay(3, 24'hABCDEF);
    req = 4'b1000;
    wait_ack("to_next_ack", 1, 20);
    req = 4'b0000;
    wait_fd("to_next_fd", 1, 200);
    check_frame("to_next", 64'h55A503ABCDEF8AF0);

    // reset asserted while byte4 is being issued
    clear_logs();
    set_pay(0, 24'h112233);
    req = 4'b0001;
    n = 0;
    k = 0;
    while (n < 5 && k < 300) begin
      tick();
      if (Send_En) n++;
      k++;
    end
    check("mr_reach_b4", n, 5);
    Reset = 1'b1;
    #1;
    check("mr_send", Send_En, 0);
    check("mr_busy", busy, 0);
    check("mr_ack", ack, 0);
    check("mr_data", Tx_Data, 0);
    req = 4'b0000;
    repeat (3) tick();
    Reset = 1'b0;
    tick();
    clear_logs();
    set_pay(1, 24'h0A0B0C);
    req = 4'b0010;
    wait_ack("mr_ack_wait", 1, 20);
    req = 4'b0000;
    wait_fd("mr_fd_wait", 1, 200);
    check_frame("mr", 64'h55A5010A0B0C0CF0);

    // stray Tx_Done in IDLE, then in the Send_En cycle
    clear_logs();
    stray_idle = 1;
    repeat (20) tick();
    check("st_idle_bytes", byte_q.size(), 0);
    check("st_idle_fd", fd_cnt, 0);
    set_pay(0, 24'h0000FF);
    stray_same = 1;
    req = 4'b0001;
    wait_ack("st_ack_wait", 1, 20);
    req = 4'b0000;
    wait_fd("st_fd_wait", 1, 200);
    repeat (5) tick();
    check("st_fd_cnt", fd_cnt, 1);
    if (send_cyc.size() > 1)
      check("st_gap", send_cyc[1] - send_cyc[0], 11);
    check_frame("st", 64'h55A5000000FFFFF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
